sh4_fpu_norm_round: RTL and testbench



---
 rtl/sh4_fpu_norm_round_pkg.sv | 35 +++
 rtl/sh4_fpu_norm_round_if.sv | 29 ++
 rtl/sh4_fpu_clz.sv | 27 ++
 rtl/sh4_fpu_norm_round.sv | 169 ++++++++++++++++
 tb/tb_sh4_fpu_norm_round.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sh4_fpu_norm_round_pkg.sv
// Shared constants, per-op control bundle and result packing for the FPU normalize/round stage.
// IEEE field widths, biases, flag bit positions and FPSCR.RM encodings live here.
package sh4_fpu_norm_round_pkg;

  localparam int SP_BIAS = 127;
  localparam int DP_BIAS = 1023;
  localparam int SP_EMAX = 255;
  localparam int DP_EMAX = 2047;
  localparam int SP_FW   = 23;
  localparam int DP_FW   = 52;

  localparam int FLAG_OV = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rm_e;

  typedef struct packed {
    logic sign;
    logic dbl;
    rm_e  rm;
    logic dn;
  } op_ctl_t;

  // Fraction is left-aligned in 52 bits so single uses the top 23.
  function automatic logic [63:0] pack_fp(input logic dbl, input logic sign,
                                          input logic [10:0] ef, input logic [51:0] frac);
    if (dbl) return {sign, ef, frac};
    return {32'b0, sign, ef[7:0], frac[51:29]};
  endfunction

endpackage

// File: rtl/sh4_fpu_norm_round_if.sv
// Operand/result handshake bundle between the FPU datapaths, the normalize/round stage and writeback.
// master drives operands and out_ready; slave is the normalize/round stage.
interface sh4_fpu_norm_round_if #(
  parameter int MW = 64,
  parameter int EW = 13
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [MW-1:0] in_mant;
  logic          in_dbl;
  logic          in_rm;
  logic          in_dn;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_result;
  logic [2:0]    out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_dbl, in_rm, in_dn, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_dbl, in_rm, in_dn, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/sh4_fpu_clz.sv
// Leading-zero counter: lz_o is the number of zeros above the highest set bit.
// All-zero input reports lz_o = 0 with zero_o = 1; callers key off zero_o.
module sh4_fpu_clz #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]         data_i,
  output logic [$clog2(WIDTH)-1:0] lz_o,
  output logic                     zero_o
);
  localparam int LZW = $clog2(WIDTH);

  logic found;

  always_comb begin
    lz_o  = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && data_i[i]) begin
        lz_o  = LZW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign zero_o = ~|data_i;

endmodule

// File: rtl/sh4_fpu_norm_round.sv
// SH4 FPU normalize/round/pack: A = register + clz, B = left-justify + rebias, C = round + pack.
// Three-deep valid/ready pipe; a stalled output holds every stage, in_ready is combinational.
module sh4_fpu_norm_round
  import sh4_fpu_norm_round_pkg::*;
#(
  parameter int MW = 64,
  parameter int EW = 13
) (
  input logic clk,
  input logic rst_n,
  sh4_fpu_norm_round_if.slave io
);
  localparam int LZW = $clog2(MW);
  localparam int SHW = $clog2(2 * MW);
  localparam int FWD = DP_FW - SP_FW;

  logic va_q, vb_q, vc_q;
  logic rdy_a, rdy_b, rdy_c;

  assign rdy_c       = !vc_q || io.out_ready;
  assign rdy_b       = !vb_q || rdy_c;
  assign rdy_a       = !va_q || rdy_b;
  assign io.in_ready = rdy_a;

  // ---------------- stage A
  op_ctl_t        ctl_in_d, ctl_a_q;
  logic [EW-1:0]  exp_a_q;
  logic [MW-1:0]  mant_a_q;
  logic [LZW-1:0] lz_d, lz_a_q;
  logic           zero_d, zero_a_q;

  assign ctl_in_d = '{sign: io.in_sign, dbl: io.in_dbl, rm: rm_e'(io.in_rm), dn: io.in_dn};

  sh4_fpu_clz #(.WIDTH(MW)) u_clz (
    .data_i (io.in_mant),
    .lz_o   (lz_d),
    .zero_o (zero_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q     <= 1'b0;
      ctl_a_q  <= '0;
      exp_a_q  <= '0;
      mant_a_q <= '0;
      lz_a_q   <= '0;
      zero_a_q <= 1'b0;
    end else if (rdy_a) begin
      va_q <= io.in_valid;
      if (io.in_valid) begin
        ctl_a_q  <= ctl_in_d;
        exp_a_q  <= io.in_exp;
        mant_a_q <= io.in_mant;
        lz_a_q   <= lz_d;
        zero_a_q <= zero_d;
      end
    end
  end

  // ---------------- stage B
  op_ctl_t            ctl_b_q;
  logic               zero_b_q;
  logic [MW-1:0]      mn_d, mn_b_q;
  logic signed [EW:0] eb_d, eb_b_q, bias_s;

  always_comb begin
    bias_s = ctl_a_q.dbl ? (EW+1)'(DP_BIAS) : (EW+1)'(SP_BIAS);
    mn_d   = mant_a_q << lz_a_q;
    eb_d   = $signed({exp_a_q[EW-1], exp_a_q})
           - $signed({{(EW+1-LZW){1'b0}}, lz_a_q}) + bias_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_q     <= 1'b0;
      ctl_b_q  <= '0;
      zero_b_q <= 1'b0;
      mn_b_q   <= '0;
      eb_b_q   <= '0;
    end else if (rdy_b) begin
      vb_q <= va_q;
      if (va_q) begin
        ctl_b_q  <= ctl_a_q;
        zero_b_q <= zero_a_q;
        mn_b_q   <= mn_d;
        eb_b_q   <= eb_d;
      end
    end
  end

  // ---------------- stage C
  logic               tiny, guard, sticky, lsb, inc, nx, ovf;
  logic [EW:0]        sh_full;
  logic [SHW-1:0]     sh;
  logic [2*MW-1:0]    ext;
  logic [DP_FW:0]     kept;
  logic [DP_FW+1:0]   inc_v, kept_r;
  logic signed [EW:0] e_post, emax_s;
  logic [10:0]        ef;
  logic [63:0]        res_d, res_q;
  logic [2:0]         flags_d, flags_q;

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    tiny    = eb_b_q[EW] || (eb_b_q == '0);
    sh_full = (EW+1)'(1) - eb_b_q;
    sh      = '0;
    // Denormal right shift; anything past the whole mantissa only feeds sticky.
    if (tiny) sh = (sh_full > (EW+1)'(2*MW-1)) ? SHW'(2*MW-1) : sh_full[SHW-1:0];
    ext = {mn_b_q, {MW{1'b0}}} >> sh;
    if (ctl_b_q.dbl) begin
      kept   = ext[2*MW-1 -: DP_FW+1];
      guard  = ext[2*MW-2-DP_FW];
      sticky = |ext[2*MW-3-DP_FW:0];
      lsb    = kept[0];
      inc_v  = (DP_FW+2)'(1);
    end else begin
      kept   = {ext[2*MW-1 -: SP_FW+1], {FWD{1'b0}}};
      guard  = ext[2*MW-2-SP_FW];
      sticky = |ext[2*MW-3-SP_FW:0];
      lsb    = kept[FWD];
      inc_v  = (DP_FW+2)'(1) << FWD;
    end
    nx     = guard | sticky;
    inc    = (ctl_b_q.rm == RM_RNE) && guard && (sticky || lsb);
    kept_r = {1'b0, kept} + (inc ? inc_v : '0);
    e_post = eb_b_q + $signed({{EW{1'b0}}, kept_r[DP_FW+1]});
    emax_s = ctl_b_q.dbl ? (EW+1)'(DP_EMAX) : (EW+1)'(SP_EMAX);
    ovf    = !tiny && (e_post >= emax_s);
    ef     = tiny ? {10'b0, kept_r[DP_FW]} : e_post[10:0];

    if (zero_b_q) begin
      res_d = pack_fp(ctl_b_q.dbl, ctl_b_q.sign, '0, '0);
    end else if (tiny && ctl_b_q.dn) begin
      res_d            = pack_fp(ctl_b_q.dbl, ctl_b_q.sign, '0, '0);
      flags_d[FLAG_UF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end else if (ovf) begin
      flags_d[FLAG_OV] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
      if (ctl_b_q.rm == RM_RNE) res_d = pack_fp(ctl_b_q.dbl, ctl_b_q.sign, 11'h7FF, '0);
      else                      res_d = pack_fp(ctl_b_q.dbl, ctl_b_q.sign, 11'h7FE, '1);
    end else begin
      res_d            = pack_fp(ctl_b_q.dbl, ctl_b_q.sign, ef, kept_r[DP_FW-1:0]);
      flags_d[FLAG_UF] = tiny && nx;
      flags_d[FLAG_NX] = nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else if (rdy_c) begin
      vc_q <= vb_q;
      if (vb_q) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign io.out_valid  = vc_q;
  assign io.out_result = res_q;
  assign io.out_flags  = flags_q;

endmodule

// File: tb/tb_sh4_fpu_norm_round.sv
// Bench for sh4_fpu_norm_round: exact-arithmetic reference model plus scoreboard,
// directed vectors pinned to hand-computed encodings, backpressure, reset flush and random traffic.
module tb_sh4_fpu_norm_round;
  localparam int MW = 64;
  localparam int EW = 13;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sh4_fpu_norm_round_if #(.MW(MW), .EW(EW)) io ();
  sh4_fpu_norm_round #(.MW(MW), .EW(EW)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  typedef struct {
    logic        sgn;
    int          ex;
    logic [63:0] mant;
    logic        dbl;
    logic        rm;
    logic        dn;
    logic [63:0] res;
    logic [2:0]  flg;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [66:0] exp_q[$];
  int          pop_cyc[$];
  logic        held_vld = 1'b0;
  logic [66:0] held;
  vec_t        vecs[17];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value = mant * 2^(ex-63); pick the ulp quantum for the format, round the
  // exact integer quotient, then encode. Returns {ov,uf,nx,result}.
  function automatic logic [66:0] model(input logic sgn, input int ex, input logic [63:0] mant,
                                        input logic dbl, input logic rm, input logic dn);
    int F, bias, emax, p, E, q, s, sh, field;
    logic [127:0] n, rem, half, one;
    logic ov, uf, nx, up, tiny;
    logic [63:0] zero, res;
    F    = dbl ? 52 : 23;
    bias = dbl ? 1023 : 127;
    emax = dbl ? 2047 : 255;
    one  = 128'd1;
    zero = dbl ? {sgn, 63'b0} : {32'b0, sgn, 31'b0};
    if (mant == 64'd0) return {3'b000, zero};
    p = 0;
    for (int i = 0; i < 64; i++) if (mant[i]) p = i;
    E    = ex + p - 63;
    tiny = (E + bias <= 0);
    if (tiny && dn) return {3'b011, zero};
    q = tiny ? (1 - bias - F) : (E - F);
    s = ex - 63 - q;
    if (s >= 0) begin
      n = {64'b0, mant} << s; rem = '0; half = '0;
    end else begin
      sh = -s;
      if (sh >= 128) begin
        n = '0; rem = {64'b0, mant}; half = '1;
      end else begin
        n    = {64'b0, mant} >> sh;
        rem  = {64'b0, mant} & ((one << sh) - one);
        half = one << (sh - 1);
      end
    end
    nx = (rem != '0);
    up = !rm && nx && ((rem > half) || (rem == half && n[0]));
    n  = n + {127'b0, up};
    if (n >= (one << (F + 1))) begin
      n = n >> 1;
      q = q + 1;
    end
    field = (n >= (one << F)) ? (q + F + bias) : 0;
    uf    = tiny && nx;
    ov    = 1'b0;
    if (field >= emax) begin
      ov = 1'b1; nx = 1'b1;
      if (!rm) res = dbl ? {sgn, 11'h7FF, 52'b0} : {32'b0, sgn, 8'hFF, 23'b0};
      else     res = dbl ? {sgn, 11'h7FE, {52{1'b1}}} : {32'b0, sgn, 8'hFE, {23{1'b1}}};
    end else begin
      res = dbl ? {sgn, 11'(field), n[51:0]} : {32'b0, sgn, 8'(field), n[22:0]};
    end
    return {ov, uf, nx, res};
  endfunction

  function automatic vec_t mk(input logic sgn, input int ex, input logic [63:0] mant,
                              input logic dbl, input logic rm, input logic dn,
                              input logic [63:0] res, input logic [2:0] flg);
    vec_t v;
    v.sgn = sgn; v.ex = ex; v.mant = mant; v.dbl = dbl; v.rm = rm; v.dn = dn;
    v.res = res; v.flg = flg;
    return v;
  endfunction

  function automatic vec_t rnd();
    vec_t v;
    logic [63:0] m;
    v.sgn = 1'($urandom_range(0, 1));
    v.dbl = 1'($urandom_range(0, 1));
    v.rm  = 1'($urandom_range(0, 1));
    v.dn  = 1'($urandom_range(0, 1));
    v.ex  = v.dbl ? int'($urandom_range(0, 2400)) - 1200 : int'($urandom_range(0, 340)) - 170;
    m     = {$urandom, $urandom};
    v.mant = ($urandom_range(0, 15) == 0) ? 64'd0 : (m >> $urandom_range(0, 63));
    v.res = '0; v.flg = '0;
    return v;
  endfunction

  // Scoreboard: accepts push model results, output handshakes pop and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (io.in_valid && io.in_ready)
        exp_q.push_back(model(io.in_sign, int'($signed(io.in_exp)), io.in_mant,
                              io.in_dbl, io.in_rm, io.in_dn));
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got %h expected none", {io.out_flags, io.out_result});
        end else begin
          check("result", {io.out_flags, io.out_result}, exp_q.pop_front());
          pop_cyc.push_back(cyc);
        end
        held_vld = 1'b0;
      end else if (io.out_valid) begin
        if (held_vld) check("stall_hold", {io.out_flags, io.out_result}, held);
        held     = {io.out_flags, io.out_result};
        held_vld = 1'b1;
      end else begin
        held_vld = 1'b0;
      end
    end
  end

  task automatic drive(input vec_t v);
    io.in_sign  = v.sgn;
    io.in_exp   = EW'(v.ex);
    io.in_mant  = v.mant;
    io.in_dbl   = v.dbl;
    io.in_rm    = v.rm;
    io.in_dn    = v.dn;
    io.in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!io.in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1", io.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 67'(exp_q.size()), 67'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, n, k;
    logic acc;
    vecs[0]  = mk(0,     0, 64'h8000000000000000, 0, 0, 0, 64'h000000003F800000, 3'b000);
    vecs[1]  = mk(0,     0, 64'h8000000000000000, 1, 0, 0, 64'h3FF0000000000000, 3'b000);
    vecs[2]  = mk(0,    63, 64'h0000000000000003, 0, 0, 0, 64'h0000000040400000, 3'b000);
    vecs[3]  = mk(1,     0, 64'h0000000000000000, 0, 0, 0, 64'h0000000080000000, 3'b000);
    vecs[4]  = mk(0,     0, 64'h8000008000000000, 0, 0, 0, 64'h000000003F800000, 3'b001);
    vecs[5]  = mk(0,     0, 64'h8000018000000000, 0, 0, 0, 64'h000000003F800002, 3'b001);
    vecs[6]  = mk(0,     0, 64'h8000018000000000, 0, 1, 0, 64'h000000003F800001, 3'b001);
    vecs[7]  = mk(0,   128, 64'h8000000000000000, 0, 0, 0, 64'h000000007F800000, 3'b101);
    vecs[8]  = mk(0,   128, 64'h8000000000000000, 0, 1, 0, 64'h000000007F7FFFFF, 3'b101);
    vecs[9]  = mk(0,  -127, 64'h8000000000000000, 0, 0, 0, 64'h0000000000400000, 3'b000);
    vecs[10] = mk(0,  -127, 64'h8000000000000000, 0, 0, 1, 64'h0000000000000000, 3'b011);
    vecs[11] = mk(0,     0, 64'hFFFFFF8000000000, 0, 0, 0, 64'h0000000040000000, 3'b001);
    vecs[12] = mk(1,  1024, 64'h8000000000000000, 1, 1, 0, 64'hFFEFFFFFFFFFFFFF, 3'b101);
    vecs[13] = mk(0, -1100, 64'h8000000000000000, 1, 0, 0, 64'h0000000000000000, 3'b011);
    vecs[14] = mk(0,  -127, 64'hFFFFFFFF00000000, 0, 0, 0, 64'h0000000000800000, 3'b011);
    vecs[15] = mk(0,    63, 64'h0000000000000003, 1, 0, 0, 64'h4008000000000000, 3'b000);
    vecs[16] = mk(0,     0, 64'h8000000000000C00, 1, 0, 0, 64'h3FF0000000000002, 3'b001);

    io.in_valid = 1'b0; io.in_sign = 1'b0; io.in_exp = '0; io.in_mant = '0;
    io.in_dbl = 1'b0; io.in_rm = 1'b0; io.in_dn = 1'b0; io.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 67'(io.out_valid), 67'd0);
    check("rst_out_data", {io.out_flags, io.out_result}, 67'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 67'(io.in_ready), 67'd1);

    foreach (vecs[i])
      check($sformatf("model_pin%0d", i),
            model(vecs[i].sgn, vecs[i].ex, vecs[i].mant, vecs[i].dbl, vecs[i].rm, vecs[i].dn),
            {vecs[i].flg, vecs[i].res});

    // Latency: presented before edge 1, visible after edge 3.
    drive(vecs[0]);
    for (k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) io.in_valid = 1'b0;
      if (k == 2) check("latency_early", 67'(io.out_valid), 67'd0);
    end
    check("latency", 67'(io.out_valid), 67'd1);
    drain("drain_latency");

    // All directed vectors back to back: one result per cycle, no bubbles.
    pop_cyc.delete();
    foreach (vecs[i]) begin
      drive(vecs[i]);
      wait_accept();
    end
    io.in_valid = 1'b0;
    drain("drain_directed");
    check("directed_count", 67'(pop_cyc.size()), 67'd17);
    if (pop_cyc.size() == 17)
      check("directed_no_bubbles", 67'(pop_cyc[16] - pop_cyc[0]), 67'd16);

    // Backpressure: three accepts fill the pipe, then in_ready drops and outputs hold.
    io.out_ready = 1'b0;
    pop_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      drive(vecs[5 + i]);
      wait_accept();
    end
    drive(vecs[8]);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("bp_in_ready", 67'(io.in_ready), 67'd0);
    check("bp_out_valid", 67'(io.out_valid), 67'd1);
    io.out_ready = 1'b1;
    wait_accept();
    drive(vecs[9]);
    wait_accept();
    io.in_valid = 1'b0;
    drain("drain_bp");
    check("bp_count", 67'(pop_cyc.size()), 67'd5);
    if (pop_cyc.size() == 5)
      check("bp_rate", 67'(pop_cyc[4] - pop_cyc[0]), 67'd4);

    // Reset with the pipe full: everything in flight is discarded.
    io.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(vecs[11 + i]);
      wait_accept();
    end
    check("full_before_rst", 67'(io.in_ready), 67'd0);
    rst_n = 1'b0;
    io.in_valid = 1'b0;
    #1;
    check("rst_flush_valid", 67'(io.out_valid), 67'd0);
    check("rst_flush_data", {io.out_flags, io.out_result}, 67'd0);
    exp_q.delete();
    held_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    io.out_ready = 1'b1;
    check("rst_release_in_ready", 67'(io.in_ready), 67'd1);
    repeat (6) begin
      @(negedge clk);
      check("post_rst_quiet", 67'(io.out_valid), 67'd0);
    end
    @(posedge clk); #1;

    // Random mixed traffic with random stalls and input gaps.
    sent = 0; n = 0;
    drive(rnd());
    while (sent < 60 && n < 3000) begin
      io.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = io.in_valid && io.in_ready;
      @(posedge clk); #1;
      if (!io.in_valid || acc) begin
        if (acc) sent++;
        if (sent < 60) begin
          drive(rnd());
          io.in_valid = ($urandom_range(0, 4) != 0);
        end else begin
          io.in_valid = 1'b0;
        end
      end
      n++;
    end
    check("random_sent", 67'(sent), 67'd60);
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
